// File: rtl/mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_pkg: shared types, widths and parity helper for the req/ack          |
// | multiplier responder.  Revision: 1.0                                     |
// +--------------------------------------------------------------------------+
package mult_pkg;

   localparam int DATA_W_C = 16;
   localparam int RES_W_C  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      MULT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Zero-extension does not change parity, so narrower vectors may be widened.
   function automatic logic parity(input logic [RES_W_C-1:0] vec);
      return ^vec;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_shift_add_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_shift_add_core: unsigned iterative shift-add multiplier, one step    |
// | per cycle, DATA_W steps.  Revision: 1.0                                  |
// +--------------------------------------------------------------------------+
module mult_shift_add_core
   import mult_pkg::*;
#(
   parameter int DATA_W = DATA_W_C,
   parameter int RES_W  = 2 * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W:0]   mcand,
   input  logic [DATA_W:0]   mplier,
   output logic              done,
   output logic [RES_W-1:0]  product
);

   localparam int              CNT_W  = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W:0]   r_hi;
   logic [DATA_W:0]   r_lo;
   logic [DATA_W:0]   r_mcand;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;

   logic [DATA_W:0]   w_hi;
   logic [DATA_W:0]   w_lo;
   logic [DATA_W:0]   w_mc;
   logic [DATA_W+1:0] w_sum;

   // The start cycle performs step 0 straight from the inputs; r_cnt then
   // tracks steps 1..DATA_W-1 and done flags the cycle of the last one.
   always_comb begin
      w_hi  = start ? '0     : r_hi;
      w_lo  = start ? mplier : r_lo;
      w_mc  = start ? mcand  : r_mcand;
      w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_mc} : '0);
   end

   assign done    = r_busy && (r_cnt == C_LAST);
   // Low product bits live in the top of r_lo; the final step's sum supplies the rest.
   assign product = RES_W'({w_sum, w_lo[DATA_W:2]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         if (start || r_busy) begin
            r_hi <= w_sum[DATA_W+1:1];
            r_lo <= {w_sum[0], w_lo[DATA_W:1]};
         end
         if (start) begin
            r_mcand <= mcand;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
         end else if (r_busy) begin
            if (r_cnt == C_LAST) begin
               r_busy <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mult_seq_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_seq_responder: req/ack signed 16x16 multiplier with operand parity   |
// | check and parity-protected registered result.  Revision: 1.0             |
// +--------------------------------------------------------------------------+
module mult_seq_responder
   import mult_pkg::*;
#(
   parameter int DATA_W = DATA_W_C,
   parameter int RES_W  = 2 * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] arg_a,
   input  logic              arg_a_parity,
   input  logic [DATA_W-1:0] arg_b,
   input  logic              arg_b_parity,
   input  logic              req,
   output logic              ack,
   output logic              result_rdy,
   output logic              arg_parity_error,
   output logic [RES_W-1:0]  result,
   output logic              result_parity
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_a_par;
   logic              r_b_par;
   logic              r_sign;

   logic              w_par_err;
   logic              w_ack_nxt;
   logic              w_rdy_nxt;
   logic              w_start;
   logic              w_load_err;
   logic              w_load_prod;
   logic              w_core_done;
   logic [DATA_W:0]   w_mag_a;
   logic [DATA_W:0]   w_mag_b;
   logic [RES_W-1:0]  w_prod;
   logic [RES_W-1:0]  w_signed;

   // One extra magnitude bit keeps |-2^(DATA_W-1)| representable.
   always_comb begin
      w_par_err = (r_a_par != parity(RES_W_C'(r_a))) ||
                  (r_b_par != parity(RES_W_C'(r_b)));
      w_mag_a   = r_a[DATA_W-1] ? ('0 - {1'b1, r_a}) : {1'b0, r_a};
      w_mag_b   = r_b[DATA_W-1] ? ('0 - {1'b1, r_b}) : {1'b0, r_b};
      w_signed  = r_sign ? ('0 - w_prod) : w_prod;
   end

   mult_shift_add_core #(
      .DATA_W (DATA_W),
      .RES_W  (RES_W)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_start),
      .mcand   (w_mag_a),
      .mplier  (w_mag_b),
      .done    (w_core_done),
      .product (w_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_rdy_nxt   = 1'b0;
      w_start     = 1'b0;
      w_load_err  = 1'b0;
      w_load_prod = 1'b0;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_state_nxt = CHECK;
               w_ack_nxt   = 1'b1;
            end
         end
         CHECK: begin
            if (w_par_err) begin
               w_state_nxt = DONE;
               w_load_err  = 1'b1;
            end else begin
               w_state_nxt = MULT;
               w_start     = 1'b1;
            end
         end
         MULT: begin
            if (w_core_done) begin
               w_state_nxt = DONE;
               w_load_prod = 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_rdy_nxt   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a              <= '0;
         r_b              <= '0;
         r_a_par          <= 1'b0;
         r_b_par          <= 1'b0;
         r_sign           <= 1'b0;
         ack              <= 1'b0;
         result_rdy       <= 1'b0;
         arg_parity_error <= 1'b0;
         result           <= '0;
         result_parity    <= 1'b0;
      end else begin
         ack        <= w_ack_nxt;
         result_rdy <= w_rdy_nxt;
         if (w_ack_nxt) begin
            r_a     <= arg_a;
            r_b     <= arg_b;
            r_a_par <= arg_a_parity;
            r_b_par <= arg_b_parity;
         end
         if (w_start) begin
            r_sign <= r_a[DATA_W-1] ^ r_b[DATA_W-1];
         end
         // Result fields change on entry to DONE; result_rdy follows a cycle later.
         if (w_load_err) begin
            arg_parity_error <= 1'b1;
            result           <= '0;
            result_parity    <= 1'b0;
         end else if (w_load_prod) begin
            arg_parity_error <= 1'b0;
            result           <= w_signed;
            result_parity    <= parity(RES_W_C'(w_signed));
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_seq_responder: table-driven bench for the multiplier responder.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_seq_responder;

   typedef struct {
      logic [15:0] a;
      logic        pa;
      logic [15:0] b;
      logic        pb;
      logic [31:0] res;
      logic        rpar;
      logic        err;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] arg_a = '0;
   logic        arg_a_parity = 1'b0;
   logic [15:0] arg_b = '0;
   logic        arg_b_parity = 1'b0;
   logic        req = 1'b0;
   logic        ack;
   logic        result_rdy;
   logic        arg_parity_error;
   logic [31:0] result;
   logic        result_parity;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[12];

   mult_seq_responder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .arg_a            (arg_a),
      .arg_a_parity     (arg_a_parity),
      .arg_b            (arg_b),
      .arg_b_parity     (arg_b_parity),
      .req              (req),
      .ack              (ack),
      .result_rdy       (result_rdy),
      .arg_parity_error (arg_parity_error),
      .result           (result),
      .result_parity    (result_parity)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Waits up to max_cycles edges for result_rdy; returns the edge count or 0.
   task automatic wait_rdy(input int max_cycles, output int lat);
      lat = 0;
      for (int i = 1; i <= max_cycles; i++) begin
         @(posedge clk); #1;
         if (result_rdy) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      arg_a = v.a; arg_a_parity = v.pa;
      arg_b = v.b; arg_b_parity = v.pb;
      req = 1'b1;
      @(posedge clk); #1;
      check({tag, " ack"}, 32'(ack), 32'd1);
      @(negedge clk);
      req = 1'b0;
      arg_a = 16'hDEAD; arg_b = 16'hBEEF;
      @(posedge clk); #1;
      check({tag, " ack_pulse"}, 32'(ack), 32'd0);
      if (result_rdy) lat = 1;
      else begin
         wait_rdy(40, lat);
         if (lat != 0) lat = lat + 1;
      end
      check({tag, " latency"}, 32'(lat), 32'(v.lat));
      check({tag, " result"}, result, v.res);
      check({tag, " result_parity"}, 32'(result_parity), 32'(v.rpar));
      check({tag, " parity_error"}, 32'(arg_parity_error), 32'(v.err));
      @(posedge clk); #1;
      check({tag, " rdy_pulse"}, 32'(result_rdy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int rdy_seen;
      vec_t v;

      vecs[0]  = '{16'h0003, 1'b0, 16'h0004, 1'b1, 32'h0000000C, 1'b0, 1'b0, 17};
      vecs[1]  = '{16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b1, 1'b0, 17};
      vecs[2]  = '{16'h8000, 1'b1, 16'h8000, 1'b1, 32'h40000000, 1'b1, 1'b0, 17};
      vecs[3]  = '{16'h8000, 1'b1, 16'h7FFF, 1'b1, 32'hC0008000, 1'b1, 1'b0, 17};
      vecs[4]  = '{16'hFFFF, 1'b0, 16'h0001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 17};
      vecs[5]  = '{16'h0005, 1'b1, 16'h0002, 1'b1, 32'h00000000, 1'b0, 1'b1, 2};
      vecs[6]  = '{16'h0005, 1'b0, 16'h0002, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
      vecs[7]  = '{16'h0005, 1'b1, 16'h0002, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
      vecs[8]  = '{16'h0000, 1'b0, 16'h1234, 1'b1, 32'h00000000, 1'b0, 1'b0, 17};
      vecs[9]  = '{16'hFFFD, 1'b1, 16'h0007, 1'b1, 32'hFFFFFFEB, 1'b0, 1'b0, 17};
      vecs[10] = '{16'h0100, 1'b1, 16'h8000, 1'b1, 32'hFF800000, 1'b1, 1'b0, 17};
      vecs[11] = '{16'h0003, 1'b0, 16'h0004, 1'b1, 32'h0000000C, 1'b0, 1'b0, 17};

      #3 rst_n = 1'b0;
      #1;
      check("reset ack", 32'(ack), 32'd0);
      check("reset result_rdy", 32'(result_rdy), 32'd0);
      check("reset parity_error", 32'(arg_parity_error), 32'd0);
      check("reset result", result, 32'd0);
      check("reset result_parity", 32'(result_parity), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // req during MULT with new operands: ignored, first product intact.
      @(negedge clk);
      arg_a = 16'h0003; arg_a_parity = 1'b0;
      arg_b = 16'h0004; arg_b_parity = 1'b1;
      req = 1'b1;
      @(posedge clk); #1;
      check("busy first ack", 32'(ack), 32'd1);
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      arg_a = 16'h1111; arg_a_parity = 1'b0;
      arg_b = 16'h2222; arg_b_parity = 1'b0;
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("busy no_ack", 32'(ack), 32'd0);
      end
      @(negedge clk);
      req = 1'b0;
      wait_rdy(30, lat);
      check("busy rdy_seen", 32'(lat != 0), 32'd1);
      check("busy result", result, 32'h0000000C);
      check("busy parity_error", 32'(arg_parity_error), 32'd0);

      // Reset pulse mid-MULT: outputs clear at once, aborted op never completes.
      @(negedge clk);
      arg_a = 16'h7FFF; arg_a_parity = 1'b1;
      arg_b = 16'h7FFF; arg_b_parity = 1'b1;
      req = 1'b1;
      @(posedge clk); #1;
      check("abort ack", 32'(ack), 32'd1);
      @(negedge clk);
      req = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort result", result, 32'd0);
      check("abort result_parity", 32'(result_parity), 32'd0);
      check("abort parity_error", 32'(arg_parity_error), 32'd0);
      check("abort result_rdy", 32'(result_rdy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (result_rdy) rdy_seen++;
      end
      check("abort no_rdy", 32'(rdy_seen), 32'd0);

      v = '{16'h0002, 1'b1, 16'hFFFD, 1'b1, 32'hFFFFFFFA, 1'b0, 1'b0, 17};
      run_op(v, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
